mem_access_stage: RTL and testbench

- MEM/WB stage of the 5-stage MIPS pipeline; sits between the EX/MEM latch and the register-file write port of the decode stage.
- Owns the data memory and performs lw/sw accesses.
- Drives the writeback interface to the decode stage: MW_MemtoReg, MW_RegWrite, MW_RD, MDR, MW_ALUout.
- Resolves branches toward fetch (PCSrc, BT); stalls the pipe during multi-cycle memory accesses.

---
 rtl/mem_access_stage_pkg.sv | 18 +
 rtl/data_memory.sv | 18 +
 rtl/mem_access_stage.sv | 92 +++++++++
 tb/tb_mem_access_stage.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared pipeline encodings (FSM states, opcodes, ALU controls)
package mem_access_stage_pkg;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_OR   = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_SUB  = 3'd6;
  localparam logic [2:0] ALU_SLT  = 3'd7;
  function automatic logic [2:0] lat_cnt(input int lat);
    return 3'(lat - 1);
  endfunction
endpackage

// File: rtl/data_memory.sv
// data_memory: word-addressed data RAM, async read, sync write, async clear
module data_memory #(
  parameter int DM_DEPTH = 64,
  parameter int AW = $clog2(DM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DM_DEPTH];
  assign rdata = mem[addr];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DM_DEPTH; i++) mem[i] <= '0;
    else if (we) mem[addr] <= wdata;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM/WB stage with data memory, wait-state FSM and branch resolve
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DM_DEPTH = 64,
  parameter int MEM_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        XM_MemtoReg,
  input  logic        XM_RegWrite,
  input  logic        XM_MemRead,
  input  logic        XM_MemWrite,
  input  logic        XM_branch,
  input  logic        XM_zero,
  input  logic [31:0] XM_BT,
  input  logic [31:0] XM_ALUout,
  input  logic [31:0] XM_MD,
  input  logic [4:0]  XM_RD,
  output logic        MW_MemtoReg,
  output logic        MW_RegWrite,
  output logic [4:0]  MW_RD,
  output logic [31:0] MDR,
  output logic [31:0] MW_ALUout,
  output logic        PCSrc,
  output logic [31:0] BT,
  output logic        stall
);
  localparam int AW = $clog2(DM_DEPTH);
  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic mem_op, done;
  logic [31:0] rdata;
  logic [AW-1:0] idx;
  logic unused_addr;
  assign mem_op = XM_MemRead | XM_MemWrite;
  assign idx = XM_ALUout[AW+1:2];
  assign unused_addr = ^{XM_ALUout[31:AW+2], XM_ALUout[1:0]};
  // done marks the edge on which the instruction retires into MW
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    done = 1'b0;
    if (state == IDLE) begin
      done = !mem_op || MEM_LAT == 0;
      if (!done) begin
        state_nx = WAIT;
        cnt_nx = lat_cnt(MEM_LAT);
      end
    end else begin
      done = cnt == 3'd0;
      cnt_nx = done ? cnt : cnt - 3'd1;
      state_nx = done ? IDLE : WAIT;
    end
  end
  assign stall = !rst && !done;
  assign PCSrc = XM_branch & XM_zero & ~stall;
  assign BT = XM_BT;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      MW_MemtoReg <= 1'b0;
      MW_RegWrite <= 1'b0;
      MW_RD <= '0;
      MW_ALUout <= '0;
      MDR <= '0;
    end else if (done) begin
      MW_MemtoReg <= XM_MemtoReg;
      MW_RegWrite <= XM_RegWrite;
      MW_RD <= XM_RD;
      MW_ALUout <= XM_ALUout;
      if (XM_MemRead) MDR <= rdata;
    end else begin
      MW_RegWrite <= 1'b0;
    end
  // rdata is sampled before the write lands, giving read-before-write
  data_memory #(.DM_DEPTH(DM_DEPTH), .AW(AW)) u_dm (
    .clk(clk),
    .rst(rst),
    .we(done & XM_MemWrite),
    .addr(idx),
    .wdata(XM_MD),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed scoreboard bench over MEM_LAT = 0, 3, 5
module tb_mem_access_stage;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic mt, rw, mr, mw, br, zr;
  logic [31:0] bt, alu, md;
  logic [4:0] rd;
  logic mw_mt [3], mw_rw [3], pcs [3], stl [3];
  logic [4:0] mw_rd [3];
  logic [31:0] mdr [3], mw_alu [3], bt_o [3];
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_access_stage #(.DM_DEPTH(64), .MEM_LAT(g == 0 ? 0 : g == 1 ? 3 : 5)) u_dut (
      .clk(clk), .rst(rst),
      .XM_MemtoReg(mt), .XM_RegWrite(rw), .XM_MemRead(mr), .XM_MemWrite(mw),
      .XM_branch(br), .XM_zero(zr), .XM_BT(bt), .XM_ALUout(alu), .XM_MD(md), .XM_RD(rd),
      .MW_MemtoReg(mw_mt[g]), .MW_RegWrite(mw_rw[g]), .MW_RD(mw_rd[g]), .MDR(mdr[g]),
      .MW_ALUout(mw_alu[g]), .PCSrc(pcs[g]), .BT(bt_o[g]), .stall(stl[g])
    );
  end
  typedef struct {
    logic [31:0] alu;
    logic [31:0] mdr;
    logic [4:0] rd;
    logic rw;
    logic mt;
    int stalls;
  } exp_t;
  exp_t q[$];
  logic [31:0] model [64];
  logic [31:0] mdr_exp;
  int lat_of [3] = '{0, 3, 5};
  int sel = 0;
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    {mt, rw, mr, mw, br, zr} = '0;
    bt = '0; alu = '0; md = '0; rd = '0;
  endtask

  task automatic do_reset(input int s);
    sel = s;
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 64; i++) model[i] = '0;
    mdr_exp = '0;
    rst = 1'b0;
    #1;
    chk("rst_mdr", mdr[sel], 0);
    chk("rst_alu", mw_alu[sel], 0);
    chk("rst_rd", 32'(mw_rd[sel]), 0);
    chk("rst_rw", 32'(mw_rw[sel]), 0);
    chk("rst_mt", 32'(mw_mt[sel]), 0);
    chk("rst_stall", 32'(stl[sel]), 0);
  endtask

  task automatic issue(input logic r, input logic w, input logic t, input logic wr,
                       input logic [4:0] d, input logic [31:0] a, input logic [31:0] data);
    exp_t e;
    int cyc;
    {mr, mw, mt, rw, br, zr} = {r, w, t, wr, 2'b00};
    rd = d; alu = a; md = data;
    if (r) mdr_exp = model[a[7:2]];
    if (w) model[a[7:2]] = data;
    e = '{alu: a, mdr: mdr_exp, rd: d, rw: wr, mt: t, stalls: (r | w) ? lat_of[sel] : 0};
    q.push_back(e);
    #1;
    cyc = 0;
    while (stl[sel] === 1'b1 && cyc < 20) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      cyc++;
      chk("bubble_rw", 32'(mw_rw[sel]), 0);
    end
    if (cyc >= 20) chk("stall_timeout", 32'(cyc), 32'(lat_of[sel]));
    @(posedge clk);
    @(negedge clk);
    #1;
    e = q.pop_front();
    chk("stall_cycles", 32'(cyc), 32'(e.stalls));
    chk("mw_alu", mw_alu[sel], e.alu);
    chk("mw_rd", 32'(mw_rd[sel]), 32'(e.rd));
    chk("mw_rw", 32'(mw_rw[sel]), 32'(e.rw));
    chk("mw_mt", 32'(mw_mt[sel]), 32'(e.mt));
    chk("mdr", mdr[sel], e.mdr);
  endtask

  initial begin
    clear_inputs();
    do_reset(0);
    issue(0, 1, 0, 0, 5'd0, 32'h10, 32'hDEADBEEF);
    issue(1, 0, 1, 1, 5'd5, 32'h10, 32'h0);
    issue(0, 0, 0, 1, 5'd9, 32'h7, 32'h0);
    issue(1, 0, 1, 1, 5'd7, 32'h0, 32'h0);
    issue(1, 0, 1, 1, 5'd6, 32'h10, 32'h0);
    issue(0, 1, 0, 0, 5'd0, 32'h100, 32'h12345678);
    issue(1, 0, 1, 1, 5'd8, 32'h0, 32'h0);
    issue(0, 1, 0, 0, 5'd0, 32'h20, 32'hAAAA5555);
    issue(1, 1, 1, 1, 5'd10, 32'h20, 32'hBBBB0000);
    issue(1, 0, 1, 1, 5'd11, 32'h23, 32'h0);
    clear_inputs();
    br = 1'b1; zr = 1'b1; bt = 32'h40;
    #1;
    chk("br_taken", 32'(pcs[0]), 1);
    chk("br_target", bt_o[0], 32'h40);
    zr = 1'b0;
    #1;
    chk("br_not_taken", 32'(pcs[0]), 0);
    @(negedge clk);
    do_reset(1);
    issue(0, 1, 0, 0, 5'd0, 32'h4, 32'hCAFEF00D);
    issue(1, 0, 1, 1, 5'd3, 32'h4, 32'h0);
    issue(0, 0, 0, 1, 5'd12, 32'h55, 32'h0);
    clear_inputs();
    br = 1'b1; zr = 1'b1; bt = 32'h80; mr = 1'b1;
    #1;
    chk("br_stall_stall", 32'(stl[1]), 1);
    chk("br_stall_pcsrc", 32'(pcs[1]), 0);
    mr = 1'b0;
    #1;
    chk("br_nostall_pcsrc", 32'(pcs[1]), 1);
    @(negedge clk);
    do_reset(2);
    mw = 1'b1; alu = 32'h8; md = 32'h55; rw = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("wait_stall", 32'(stl[2]), 1);
    rst = 1'b1;
    #1;
    chk("abort_stall", 32'(stl[2]), 0);
    chk("abort_mdr", mdr[2], 0);
    chk("abort_alu", mw_alu[2], 0);
    chk("abort_rd", 32'(mw_rd[2]), 0);
    chk("abort_rw", 32'(mw_rw[2]), 0);
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    issue(1, 0, 1, 1, 5'd4, 32'h8, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
